// File: rtl/o_buf_ser_pkg.sv
// Shared definitions for the o_buf_ser output pad serializer: state encoding,
// legal WIDTH range and the accepted WEAK_KEEPER settings.
package o_buf_ser_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int WIDTH_MIN = 3;
    localparam int WIDTH_MAX = 10;

    localparam string KEEPER_NONE     = "NONE";
    localparam string KEEPER_PULLUP   = "PULLUP";
    localparam string KEEPER_PULLDOWN = "PULLDOWN";

endpackage

// File: rtl/o_buf_ser_pad.sv
// Tristate pad stage: drives O from the registered bit while enabled, otherwise
// releases it, optionally holding it with a weak pull.
module o_buf_ser_pad
    import o_buf_ser_pkg::*;
#(
    parameter string WEAK_KEEPER = "NONE"
) (
    input  logic out_bit,
    input  logic oe,
    output wire  O
);

    assign O = oe ? out_bit : 1'bz;

    generate
        if (WEAK_KEEPER == KEEPER_PULLUP) begin : g_pullup
            pullup (O);
        end else if (WEAK_KEEPER == KEEPER_PULLDOWN) begin : g_pulldown
            pulldown (O);
        end
    endgenerate

endmodule

// File: rtl/o_buf_ser.sv
// Output-side serializer: takes WIDTH-bit words over valid/ready and shifts
// them LSB-first onto a single pad, one bit per CLK, back-to-back when fed.
module o_buf_ser
    import o_buf_ser_pkg::*;
#(
    parameter int    WIDTH       = 4,
    parameter string WEAK_KEEPER = "NONE"
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             DATA_VALID,
    input  logic             OE_IN,
    output logic             READY,
    output wire              O,
    output logic             OE
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    initial begin
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin
            $fatal(1, "%m: illegal WIDTH=%0d; valid values are %0d..%0d",
                   WIDTH, WIDTH_MIN, WIDTH_MAX);
        end
        if (WEAK_KEEPER != KEEPER_NONE && WEAK_KEEPER != KEEPER_PULLUP &&
            WEAK_KEEPER != KEEPER_PULLDOWN) begin
            $fatal(1, "%m: illegal WEAK_KEEPER=\"%s\"; valid values are %s, %s, %s",
                   WEAK_KEEPER, KEEPER_NONE, KEEPER_PULLUP, KEEPER_PULLDOWN);
        end
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;
    logic             out_bit;
    logic             oe_q;
    logic             accept;

    // Ready on the last bit of a word too, so a new word follows with no gap.
    assign READY  = !RST && (state == ST_IDLE || cnt == CNT_LAST);
    assign accept = DATA_VALID && READY;
    assign OE     = oe_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            shreg   <= '0;
            out_bit <= 1'b0;
            oe_q    <= 1'b0;
        end else if (accept) begin
            state   <= ST_SHIFT;
            cnt     <= '0;
            shreg   <= D >> 1;
            out_bit <= D[0];
            oe_q    <= OE_IN;
        end else if (state == ST_SHIFT) begin
            if (cnt != CNT_LAST) begin
                cnt     <= cnt + CNT_W'(1);
                shreg   <= shreg >> 1;
                out_bit <= shreg[0];
            end else begin
                state   <= ST_IDLE;
                cnt     <= '0;
                out_bit <= 1'b0;
                oe_q    <= 1'b0;
            end
        end
    end

    o_buf_ser_pad #(
        .WEAK_KEEPER(WEAK_KEEPER)
    ) u_pad (
        .out_bit(out_bit),
        .oe     (oe_q),
        .O      (O)
    );

endmodule

// File: tb/tb_o_buf_ser.sv
// Bench for o_buf_ser: directed vector table and randomized traffic on a
// 4-bit pulled-up instance, plus a mid-word reset sequence on an 8-bit instance.
module tb_o_buf_ser;

    logic       CLK = 1'b0;
    always #5 CLK = ~CLK;

    // 4-bit instance with pull-up keeper
    logic       RST = 1'b1;
    logic [3:0] D = '0;
    logic       DATA_VALID = 1'b0;
    logic       OE_IN = 1'b0;
    logic       READY;
    wire        O;
    logic       OE;

    // 8-bit instance, no keeper
    logic       RST8 = 1'b1;
    logic [7:0] D8 = '0;
    logic       DV8 = 1'b0;
    logic       OE_IN8 = 1'b0;
    logic       READY8;
    wire        O8;
    logic       OE8;

    o_buf_ser #(.WIDTH(4), .WEAK_KEEPER("PULLUP")) u_dut (
        .CLK(CLK), .RST(RST), .D(D), .DATA_VALID(DATA_VALID), .OE_IN(OE_IN),
        .READY(READY), .O(O), .OE(OE)
    );

    o_buf_ser #(.WIDTH(8), .WEAK_KEEPER("NONE")) u_dut8 (
        .CLK(CLK), .RST(RST8), .D(D8), .DATA_VALID(DV8), .OE_IN(OE_IN8),
        .READY(READY8), .O(O8), .OE(OE8)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: queue of {oe, bit} that the pad will show, head = now.
    logic [1:0] pad_q[$];

    function automatic logic model_ready(input logic r);
        return !r && (pad_q.size() <= 1);
    endfunction

    task automatic model_step(input logic r, input logic v, input logic [3:0] d,
                              input logic oe_in);
        logic acc;
        acc = v && model_ready(r);
        if (r) begin
            pad_q.delete();
        end else begin
            if (pad_q.size() > 0) void'(pad_q.pop_front());
            if (acc) for (int i = 0; i < 4; i++) pad_q.push_back({oe_in, d[i]});
        end
    endtask

    // Apply one cycle of inputs; returns READY before the edge and O/OE after it.
    task automatic cycle(input logic r, input logic v, input logic [3:0] d, input logic oe_in,
                         input bit use_model, output logic rdy, output logic o_s,
                         output logic oe_s);
        logic exp_o, exp_oe;
        RST = r; DATA_VALID = v; D = d; OE_IN = oe_in;
        #1;
        rdy = READY;
        if (use_model) chk("ready_model", {7'b0, READY}, {7'b0, model_ready(r)});
        @(posedge CLK);
        model_step(r, v, d, oe_in);
        @(negedge CLK);
        o_s = O; oe_s = OE;
        if (use_model) begin
            if (pad_q.size() == 0) begin
                exp_oe = 1'b0; exp_o = 1'b1;
            end else begin
                exp_oe = pad_q[0][1];
                exp_o  = pad_q[0][1] ? pad_q[0][0] : 1'b1;
            end
            chk("oe_model", {7'b0, OE}, {7'b0, exp_oe});
            chk("o_model", {7'b0, O}, {7'b0, exp_o});
        end
    endtask

    task automatic c8(input logic r, input logic v, input logic [7:0] d, input logic exp_rdy);
        RST8 = r; DV8 = v; D8 = d; OE_IN8 = 1'b1;
        #1;
        chk("ready8", {7'b0, READY8}, {7'b0, exp_rdy});
        @(posedge CLK);
        @(negedge CLK);
    endtask

    typedef struct {
        logic       rst;
        logic       dv;
        logic [3:0] d;
        logic       oe_in;
        logic       exp_ready;
        logic       exp_o;
        logic       exp_oe;
    } vec_t;

    vec_t tbl[27];

    initial begin
        logic rdy, o_s, oe_s;
        logic [7:0] w8;

        // reset, then idle
        tbl[0]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        // single word 1011 -> 1,1,0,1 then released (pull-up reads 1)
        tbl[4]  = '{1'b0, 1'b1, 4'hB, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        // back-to-back A then 5 -> 0,1,0,1,1,0,1,0
        tbl[9]  = '{1'b0, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        // disabled word: pad released for 4 cycles, then a driven word 0110
        tbl[18] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[21] = '{1'b0, 1'b1, 4'h6, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[22] = '{1'b0, 1'b1, 4'h6, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[23] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[24] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[25] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[26] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};

        @(negedge CLK);
        for (int i = 0; i < 27; i++) begin
            cycle(tbl[i].rst, tbl[i].dv, tbl[i].d, tbl[i].oe_in, 1'b0, rdy, o_s, oe_s);
            chk($sformatf("tbl%0d_ready", i), {7'b0, rdy}, {7'b0, tbl[i].exp_ready});
            chk($sformatf("tbl%0d_o", i), {7'b0, o_s}, {7'b0, tbl[i].exp_o});
            chk($sformatf("tbl%0d_oe", i), {7'b0, oe_s}, {7'b0, tbl[i].exp_oe});
        end

        // randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 6),
                  4'($urandom), 1'($urandom), 1'b1, rdy, o_s, oe_s);
        end
        cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, rdy, o_s, oe_s);

        // 8-bit instance: reset in the middle of an all-ones word
        c8(1'b1, 1'b0, 8'h00, 1'b0);
        c8(1'b0, 1'b1, 8'hFF, 1'b1);
        chk("w8_bit0_o", {7'b0, O8}, 8'h01);
        chk("w8_bit0_oe", {7'b0, OE8}, 8'h01);
        for (int i = 1; i < 3; i++) begin
            c8(1'b0, 1'b0, 8'h00, 1'b0);
            chk($sformatf("w8_bit%0d_o", i), {7'b0, O8}, 8'h01);
            chk($sformatf("w8_bit%0d_oe", i), {7'b0, OE8}, 8'h01);
        end
        c8(1'b1, 1'b1, 8'hFF, 1'b0);
        chk("w8_rst_oe", {7'b0, OE8}, 8'h00);
        c8(1'b0, 1'b0, 8'h00, 1'b1);
        chk("w8_after_rst_oe", {7'b0, OE8}, 8'h00);
        w8 = 8'h02;
        c8(1'b0, 1'b1, w8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) c8(1'b0, 1'b0, 8'h00, 1'b0);
            chk($sformatf("w8b_bit%0d_o", i), {7'b0, O8}, {7'b0, w8[i]});
            chk($sformatf("w8b_bit%0d_oe", i), {7'b0, OE8}, 8'h01);
        end
        c8(1'b0, 1'b0, 8'h00, 1'b1);
        chk("w8b_release_oe", {7'b0, OE8}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/o_buf_ser.md
# o_buf_ser

Registered output-side pad driver: accepts parallel words from fabric over a valid/ready handshake and shifts them LSB-first onto a single top-level pad, one bit per `CLK`. It is the transmit counterpart of the input buffer path. It drives the pad only while a word with output-enable is being shifted, and otherwise releases the pad to high-Z under an optional weak keeper.

## Interface
Parameters:
- `WIDTH`, 4: bits per word; legal range 3..10.
- `WEAK_KEEPER`, "NONE": keeper on `O` when released; "NONE", "PULLUP" or "PULLDOWN".

Ports (single clock domain; synchronous, active-high reset):
- `CLK`  input  1  clock; all state updates on its rising edge.
- `RST`  input  1  synchronous active-high reset.
- `D`  input  WIDTH  parallel data word from fabric.
- `DATA_VALID`  input  1  `D`/`OE_IN` hold a word to send.
- `OE_IN`  input  1  per-word output enable; sampled with the word.
- `READY`  output  1  a word is accepted at this edge if `DATA_VALID` is high.
- `O`  output  1  pad data (connect to top-level port); `1'bz` when released.
- `OE`  output  1  1 while `O` is actively driven.

## Operation
- States are IDLE and SHIFT. Internal registers:
  - `out_bit` (drives `O`)
  - `oe_q`
  - `shreg[WIDTH-1:0]`
  - `cnt` (index of the bit currently on the pad, width clog2(WIDTH))
- `READY` is combinational: `!RST && (state==IDLE || cnt==WIDTH-1)`.
- Accept = `DATA_VALID && READY`. On accept:
  - `out_bit <= D[0]`, `shreg <= D >> 1`, `oe_q <= OE_IN`, `cnt <= 0`, state becomes SHIFT.
- SHIFT with `cnt < WIDTH-1`:
  - `out_bit <= shreg[0]`, `shreg <= shreg >> 1`, `cnt <= cnt+1`.
- SHIFT with `cnt == WIDTH-1`:
  - If accept: load the new word (back-to-back, no gap).
  - Otherwise: state becomes IDLE, `oe_q <= 0`, `out_bit <= 0`.
- `O = oe_q ? out_bit : 1'bz`; `OE = oe_q`.
- A word with `OE_IN=0` still occupies WIDTH cycles; the pad stays released for its duration.
- `WEAK_KEEPER` adds `pullup`/`pulldown` on `O`. A released pad then reads 1/0; with "NONE" it reads z.
- `D` and `OE_IN` are ignored when not accepted. `DATA_VALID` may drop without penalty.
- Illegal `WIDTH` or `WEAK_KEEPER` calls `$fatal(1, ...)` in an initial block. The message names the instance (`%m`) and the valid values.

## Timing
- Reset values (registered at the edge where `RST`=1):
  - state IDLE, `cnt` 0, `shreg` 0, `out_bit` 0, `oe_q` 0.
  - Hence `O`=z, `OE`=0, and `READY`=0 while `RST` is high.
- Latency: a word accepted at edge k puts bit i on `O` during cycle k+1+i, for i = 0..WIDTH-1.
- Back-to-back: the next word may be accepted at edge k+WIDTH; its bit 0 appears in cycle k+WIDTH+1, giving a continuous stream.
- Without a new word at edge k+WIDTH, the pad is released from cycle k+WIDTH+1.
- Throughput: one word per WIDTH cycles maximum.
- Reset mid-word: the word is abandoned; the pad is released in the cycle after the reset edge and no partial bits resume.
- `DATA_VALID` with `RST` high is not accepted.
- `OE` changes only on word boundaries. It never toggles within a word.

## Structure
- Shared package `o_buf_ser_pkg` holds:
  - state encoding constants (`ST_IDLE`, `ST_SHIFT`)
  - `WIDTH` min/max constants
  - the legal `WEAK_KEEPER` strings
- One natural sub-module, `o_buf_ser_pad`:
  - takes `out_bit`/`oe_q`, produces the tristate `O`;
  - instantiates the keeper under `generate`.
- The serializer FSM, counter and shift register stay in `o_buf_ser`.

## Test plan
- Reset/idle: `RST`=1 for 3 cycles, then 0 with `DATA_VALID`=0 -> `O`=z, `OE`=0 throughout; `READY`=0 during reset and 1 after.
- Single word: `WIDTH`=4, accept `D`=4'b1011 with `OE_IN`=1 at edge k -> `O` = 1,1,0,1 in cycles k+1..k+4; `OE`=1 for those cycles; z from k+5.
- Back-to-back: accept 4'hA then 4'h5 with `DATA_VALID` held high -> `O` = 0,1,0,1,1,0,1,0 with no gap; `READY` high only in the cycles with `cnt`=3.
- Disabled word plus keeper: `WEAK_KEEPER`="PULLUP", accept 4'h0 with `OE_IN`=0 -> `O` reads 1 and `OE`=0 for 4 cycles; the next word with `OE_IN`=1 drives normally.
- Reset mid-word: `WIDTH`=8, accept 8'hFF, assert `RST` after bit 2 -> `O`=z from the cycle after the reset edge; the next accepted word starts at bit 0.
- Parameter check: `WIDTH`=11 or `WEAK_KEEPER`="KEEP" -> simulation terminates with a `$fatal` naming the instance.
